// File: rtl/nes_controller_reader.sv
// Serial reader for one NES game pad: periodically latches the pad, clocks out 8 button bits
// and presents them as a registered active-high vector with a one-cycle valid strobe.
module nes_controller_reader #(
  parameter int LATCH_CYCLES = 300,
  parameter int HALF_CYCLES  = 150,
  parameter int POLL_CYCLES  = 416667
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       nes_data,
  output logic       nes_clk,
  output logic       nes_latch,
  output logic [7:0] buttons,
  output logic       buttons_valid,
  output logic       scan_busy
);

  localparam int PW  = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int PHMAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int PHW = (PHMAX > 1) ? $clog2(PHMAX) : 1;

  localparam logic [PW-1:0]  POLL_LAST  = PW'(POLL_CYCLES - 1);
  localparam logic [PHW-1:0] LATCH_LAST = PHW'(LATCH_CYCLES - 1);
  localparam logic [PHW-1:0] HALF_LAST  = PHW'(HALF_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    LOW,
    HIGH,
    DONE
  } state_t;

  state_t         state;
  logic [PW-1:0]  poll_cnt;
  logic [PHW-1:0] phase;
  logic [2:0]     bit_idx;
  logic [7:0]     shift;
  logic           sync_meta;
  logic           sync_data;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      poll_cnt      <= '0;
      phase         <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      sync_meta     <= 1'b0;
      sync_data     <= 1'b0;
      nes_clk       <= 1'b0;
      nes_latch     <= 1'b0;
      buttons       <= '0;
      buttons_valid <= 1'b0;
      scan_busy     <= 1'b0;
    end else begin
      sync_meta     <= nes_data;
      sync_data     <= sync_meta;
      poll_cnt      <= (poll_cnt == POLL_LAST) ? '0 : poll_cnt + 1'b1;
      buttons_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (poll_cnt == '0) begin
            state     <= LATCH;
            nes_latch <= 1'b1;
            scan_busy <= 1'b1;
            phase     <= '0;
          end
        end
        LATCH: begin
          if (phase == LATCH_LAST) begin
            state     <= LOW;
            nes_latch <= 1'b0;
            phase     <= '0;
            bit_idx   <= '0;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        LOW: begin
          // The pad's data line has settled for the whole low half; take it at the end.
          if (phase == HALF_LAST) begin
            shift[bit_idx] <= sync_data;
            state          <= HIGH;
            nes_clk        <= 1'b1;
            phase          <= '0;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        HIGH: begin
          if (phase == HALF_LAST) begin
            nes_clk <= 1'b0;
            phase   <= '0;
            if (bit_idx == 3'd7) begin
              state <= DONE;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              state   <= LOW;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
        DONE: begin
          buttons       <= ~shift;
          buttons_valid <= 1'b1;
          scan_busy     <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          state     <= IDLE;
          nes_clk   <= 1'b0;
          nes_latch <= 1'b0;
          scan_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nes_controller_reader.sv
// Bench for nes_controller_reader: behavioural pad model, randomized button patterns and
// an asynchronous data mode checked against the 2-flop sampling rule.
module tb_nes_controller_reader;

  localparam int LC = 4;
  localparam int HC = 4;
  localparam int PC = 100;
  localparam int SCAN_LEN = LC + 16 * HC + 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       nes_data;
  logic       nes_clk;
  logic       nes_latch;
  logic [7:0] buttons;
  logic       buttons_valid;
  logic       scan_busy;

  always #5 clk = ~clk;

  nes_controller_reader #(
    .LATCH_CYCLES(LC),
    .HALF_CYCLES (HC),
    .POLL_CYCLES (PC)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .nes_data     (nes_data),
    .nes_clk      (nes_clk),
    .nes_latch    (nes_latch),
    .buttons      (buttons),
    .buttons_valid(buttons_valid),
    .scan_busy    (scan_busy)
  );

  int errors = 0;
  int checks = 0;

  // Pad model: 0 = button pad, 1 = line high (absent), 2 = line low, 3 = random async toggling.
  int         mode = 0;
  logic [7:0] pad_buttons = 8'h00;
  logic       async_val = 1'b1;
  int         pad_index = 0;

  always @(posedge nes_latch or posedge nes_clk) begin
    if (nes_latch) pad_index <= 0;
    else           pad_index <= pad_index + 1;
  end

  always_comb begin
    nes_data = 1'b1;
    case (mode)
      0:       nes_data = (pad_index < 8) ? ~pad_buttons[pad_index[2:0]] : 1'b1;
      1:       nes_data = 1'b1;
      2:       nes_data = 1'b0;
      default: nes_data = async_val;
    endcase
  end

  always begin
    @(negedge clk);
    #2;
    if (mode == 3) async_val = 1'($urandom_range(0, 1));
    @(posedge clk);
    #3;
    if (mode == 3) async_val = 1'($urandom_range(0, 1));
  end

  // Cycle-level observer: data history, nes_clk rises, latch/clk overlap, latch period.
  int   cyc = 0;
  int   clk_rises = 0;
  int   overlaps = 0;
  int   last_latch_rise = 0;
  int   latch_period = 0;
  logic prev_clk = 1'b0;
  logic prev_latch = 1'b0;
  logic hist [4096];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    hist[(cyc + 1) % 4096] <= nes_data;
    prev_clk <= nes_clk;
    prev_latch <= nes_latch;
    if (nes_clk && !prev_clk) clk_rises <= clk_rises + 1;
    if (nes_clk && nes_latch) overlaps <= overlaps + 1;
    if (nes_latch && !prev_latch) begin
      latch_period <= cyc - last_latch_rise;
      last_latch_rise <= cyc;
    end
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_latch(input logic [7:0] hold, output int s);
    int n;
    bit held;
    n = 0;
    held = 1'b1;
    while (!nes_latch && n < 3 * PC) begin
      tick();
      n++;
      if (!nes_latch && buttons !== hold) held = 1'b0;
    end
    chk(32'(nes_latch), 1, "latch_rise_timeout");
    chk(32'(held), 1, "buttons_hold_between_scans");
    s = cyc;
  endtask

  // s: cycle number at which the latch was first seen high.
  task automatic finish_scan(input int s, input logic [7:0] hold, input logic [7:0] exp_in,
                             input bit use_hist, input bit chk_period, input string tag,
                             output logic [7:0] exp);
    bit busy_ok;
    bit hold_ok;
    int r0;
    int o0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    r0 = clk_rises;
    o0 = overlaps;
    while (!buttons_valid && (cyc - s) < 2 * SCAN_LEN) begin
      if (!scan_busy) busy_ok = 1'b0;
      if (buttons !== hold) hold_ok = 1'b0;
      tick();
    end
    exp = exp_in;
    if (use_hist)
      for (int b = 0; b < 8; b++) exp[b] = ~hist[(s + 2 * HC - 2 + 2 * HC * b) % 4096];
    chk(32'(buttons_valid), 1, {tag, " valid_timeout"});
    chk(cyc - s, SCAN_LEN, {tag, " valid_latency"});
    chk(32'(buttons), 32'(exp), {tag, " buttons"});
    chk(32'(busy_ok), 1, {tag, " busy_during_scan"});
    chk(32'(hold_ok), 1, {tag, " buttons_hold_during_scan"});
    chk(32'(scan_busy), 0, {tag, " busy_after_done"});
    chk(clk_rises - r0, 8, {tag, " nes_clk_rises"});
    chk(overlaps - o0, 0, {tag, " latch_clk_overlap"});
    if (chk_period) chk(latch_period, PC, {tag, " latch_period"});
    tick();
    chk(32'(buttons_valid), 0, {tag, " valid_one_cycle"});
  endtask

  initial begin
    int s;
    logic [7:0] cur;
    logic [7:0] rnd;

    // Reset behaviour and first scan timing
    mode = 0;
    pad_buttons = 8'h01;
    reset_n = 1'b0;
    repeat (5) begin
      tick();
      chk(32'({nes_clk, nes_latch, buttons_valid, scan_busy, buttons}), 0, "reset_outputs");
    end
    reset_n = 1'b1;
    tick();
    s = cyc;
    chk(32'(nes_latch), 1, "latch_cycle1");
    chk(32'(scan_busy), 1, "busy_at_start");
    for (int i = 2; i <= LC; i++) begin
      tick();
      chk(32'(nes_latch), 1, "latch_held");
    end
    tick();
    chk(32'(nes_latch), 0, "latch_fall");
    finish_scan(s, 8'h00, 8'h01, 1'b0, 1'b0, "pad_A", cur);

    pad_buttons = 8'h90;
    wait_latch(cur, s);
    finish_scan(s, cur, 8'h90, 1'b0, 1'b1, "up_right", cur);
    pad_buttons = 8'h00;
    wait_latch(cur, s);
    finish_scan(s, cur, 8'h00, 1'b0, 1'b1, "release_all", cur);

    mode = 1;
    wait_latch(cur, s);
    finish_scan(s, cur, 8'h00, 1'b0, 1'b1, "data_tied_high", cur);
    mode = 2;
    wait_latch(cur, s);
    finish_scan(s, cur, 8'hFF, 1'b0, 1'b1, "data_tied_low", cur);

    mode = 0;
    repeat (3) begin
      rnd = 8'($urandom);
      pad_buttons = rnd;
      wait_latch(cur, s);
      finish_scan(s, cur, rnd, 1'b0, 1'b1, "random_pad", cur);
    end

    // Reset during the high half of bit 3
    pad_buttons = 8'hA5;
    wait_latch(cur, s);
    repeat (LC + 7 * HC + 1) tick();
    chk(32'(nes_clk), 1, "in_high_bit3");
    reset_n = 1'b0;
    tick();
    chk(32'(nes_clk), 0, "midscan_reset_clk");
    chk(32'(nes_latch), 0, "midscan_reset_latch");
    chk(32'(buttons), 0, "midscan_reset_buttons");
    chk(32'(buttons_valid), 0, "midscan_reset_valid");
    chk(32'(scan_busy), 0, "midscan_reset_busy");
    repeat (2) begin
      tick();
      chk(32'(buttons_valid), 0, "reset_no_valid");
    end
    rnd = 8'($urandom);
    pad_buttons = rnd;
    reset_n = 1'b1;
    tick();
    s = cyc;
    for (int i = 1; i <= LC; i++) begin
      if (i > 1) tick();
      chk(32'(nes_latch), 1, "post_reset_latch");
    end
    tick();
    chk(32'(nes_latch), 0, "post_reset_latch_fall");
    finish_scan(s, 8'h00, rnd, 1'b0, 1'b0, "post_reset_scan", cur);

    // Asynchronous toggling data line
    mode = 3;
    repeat (4) begin
      wait_latch(cur, s);
      finish_scan(s, cur, 8'h00, 1'b1, 1'b1, "async_data", cur);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
